// File: rtl/wb_regfile.sv
// Write-back register file: 31 stored GPRs ($0 hard-wired to zero), HI/LO pair,
// and two combinational decode read ports with same-cycle write-back bypass.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_wd,
    input  logic        wb_wreg,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    input  logic        wb_whilo,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // GPR[0] has no storage; entries 1..31 only.
    logic [31:0] gpr_q [1:31];
    logic [31:0] gpr_d [1:31];
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Storage lookup by address; address 0 falls through to zero.
    function automatic logic [31:0] gpr_lookup(input logic [4:0] addr);
        logic [31:0] val;
        val = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (addr == 5'(i)) val = gpr_q[i];
        end
        return val;
    endfunction

    // Next-state for the GPRs: commit the retiring write unless it targets $0.
    always_comb begin
        for (int unsigned i = 1; i < 32; i++) begin
            gpr_d[i] = gpr_q[i];
            if (wb_wreg && (wb_wd == 5'(i))) gpr_d[i] = wb_wdata;
        end
    end

    // Next-state for HI/LO: always written as a pair.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wb_whilo) begin
            hi_d = wb_hi;
            lo_d = wb_lo;
        end
    end

    // Architectural state; asynchronous active-low clear beats any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 1; i < 32; i++) gpr_q[i] <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            for (int unsigned i = 1; i < 32; i++) gpr_q[i] <= gpr_d[i];
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Read port 1: reset, $0, bypass, storage, disabled -- in that priority.
    always_comb begin
        rdata1 = '0;
        if (!rst)                                 rdata1 = '0;
        else if (raddr1 == 5'd0)                  rdata1 = '0;
        else if (re1 && wb_wreg && wb_wd == raddr1) rdata1 = wb_wdata;
        else if (re1)                             rdata1 = gpr_lookup(raddr1);
    end

    // Read port 2: same priority as port 1, fully independent.
    always_comb begin
        rdata2 = '0;
        if (!rst)                                 rdata2 = '0;
        else if (raddr2 == 5'd0)                  rdata2 = '0;
        else if (re2 && wb_wreg && wb_wd == raddr2) rdata2 = wb_wdata;
        else if (re2)                             rdata2 = gpr_lookup(raddr2);
    end

    // HI/LO expose committed state only; in-flight values are forwarded in EX.
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, monitor compares.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    typedef enum logic [1:0] {S_RD1, S_RD2, S_HI, S_LO} sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    event  sample_ev;
    int    errors = 0;
    int    checks = 0;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .wb_wd    (wb_wd),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .wb_whilo (wb_whilo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: on each sample point, drain the scoreboard and compare.
    initial begin
        item_t       e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.sel)
                    S_RD1:   act = rdata1;
                    S_RD2:   act = rdata2;
                    S_HI:    act = hi_o;
                    default: act = lo_o;
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push_exp(input string n, input sel_t s, input logic [31:0] v);
        item_t e;
        e.name = n;
        e.sel  = s;
        e.exp  = v;
        q.push_back(e);
    endtask

    // Sample point: 1 time unit after inputs settle, well away from the rising edge.
    task automatic sample();
        #1;
        ->sample_ev;
        #1;
    endtask

    // Advance through one rising edge and return to the low phase.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wb_wreg  = 1'b0;
        wb_wd    = 5'd0;
        wb_wdata = '0;
        wb_whilo = 1'b0;
        wb_hi    = '0;
        wb_lo    = '0;
    endtask

    task automatic gpr_write(input logic [4:0] a, input logic [31:0] d);
        wb_wreg  = 1'b1;
        wb_wd    = a;
        wb_wdata = d;
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        re1 = 1'b1; raddr1 = 5'd5;
        re2 = 1'b1; raddr2 = 5'd5;
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hCAFE_F00D;
        wb_whilo = 1'b1; wb_hi = 32'h5A5A_5A5A; wb_lo = 32'hA5A5_A5A5;
        @(negedge clk);
        // Reset beats bypass on the read ports and beats pending writes.
        push_exp("rst_rd1", S_RD1, 32'h0);
        push_exp("rst_rd2", S_RD2, 32'h0);
        push_exp("rst_hi",  S_HI,  32'h0);
        push_exp("rst_lo",  S_LO,  32'h0);
        sample();
        tick();
        idle();
        rst = 1'b1;
        push_exp("rst_no_commit_gpr", S_RD1, 32'h0);
        push_exp("rst_no_commit_hi",  S_HI,  32'h0);
        sample();

        // Populate GPR5 and HI/LO, then assert reset asynchronously mid-cycle.
        wb_whilo = 1'b1; wb_hi = 32'hAAAA_0000; wb_lo = 32'h0000_5555;
        gpr_write(5'd5, 32'h1234_5678);
        push_exp("pre_rst_gpr5", S_RD1, 32'h1234_5678);
        push_exp("pre_rst_hi",   S_HI,  32'hAAAA_0000);
        sample();
        rst = 1'b0;
        push_exp("async_rst_rd1", S_RD1, 32'h0);
        push_exp("async_rst_hi",  S_HI,  32'h0);
        push_exp("async_rst_lo",  S_LO,  32'h0);
        sample();
        rst = 1'b1;
        push_exp("post_rst_gpr5", S_RD1, 32'h0);
        sample();
        tick();
        push_exp("post_rst_gpr5_edge", S_RD1, 32'h0);
        sample();

        // Basic write then read; disabled port reads zero.
        gpr_write(5'd7, 32'hDEAD_BEEF);
        raddr1 = 5'd7;
        push_exp("rd_gpr7", S_RD1, 32'hDEAD_BEEF);
        sample();
        re1 = 1'b0;
        push_exp("rd_gpr7_disabled", S_RD1, 32'h0);
        sample();
        re1 = 1'b1;

        // Bypass on both ports over an older stored value.
        gpr_write(5'd9, 32'h0000_0001);
        raddr1 = 5'd9; raddr2 = 5'd9;
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h0000_0042;
        push_exp("bypass_rd1", S_RD1, 32'h0000_0042);
        push_exp("bypass_rd2", S_RD2, 32'h0000_0042);
        sample();
        tick();
        idle();
        push_exp("stored_rd1", S_RD1, 32'h0000_0042);
        push_exp("stored_rd2", S_RD2, 32'h0000_0042);
        sample();

        // Bypass must not fire with wb_wreg low, even on an address match.
        wb_wreg = 1'b0; wb_wd = 5'd7; wb_wdata = 32'h0BAD_BAD0;
        raddr1 = 5'd7;
        push_exp("no_bypass_wreg0", S_RD1, 32'hDEAD_BEEF);
        sample();
        tick();
        idle();
        push_exp("no_write_wreg0", S_RD1, 32'hDEAD_BEEF);
        sample();

        // $0 is never written and never bypassed.
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF;
        raddr1 = 5'd0; raddr2 = 5'd0;
        push_exp("r0_same_cycle_rd1", S_RD1, 32'h0);
        push_exp("r0_same_cycle_rd2", S_RD2, 32'h0);
        sample();
        tick();
        idle();
        push_exp("r0_next_cycle", S_RD1, 32'h0);
        sample();

        // HI/LO: no bypass before the edge; paired update with a GPR write after.
        wb_whilo = 1'b1; wb_hi = 32'h0BAD_0000; wb_lo = 32'h0000_0BAD;
        tick();
        idle();
        wb_whilo = 1'b1; wb_hi = 32'h1111_1111; wb_lo = 32'h2222_2222;
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h0000_0003;
        push_exp("hi_before_edge", S_HI, 32'h0BAD_0000);
        push_exp("lo_before_edge", S_LO, 32'h0000_0BAD);
        sample();
        tick();
        idle();
        raddr1 = 5'd3;
        push_exp("hi_after_edge", S_HI,  32'h1111_1111);
        push_exp("lo_after_edge", S_LO,  32'h2222_2222);
        push_exp("gpr3_with_hilo", S_RD1, 32'h0000_0003);
        sample();

        // Dual port, distinct registers including the top one.
        gpr_write(5'd4,  32'h0000_0004);
        gpr_write(5'd31, 32'h0000_001F);
        raddr1 = 5'd4; raddr2 = 5'd31;
        push_exp("dual_rd1", S_RD1, 32'h0000_0004);
        push_exp("dual_rd2", S_RD2, 32'h0000_001F);
        sample();
        push_exp("hi_held", S_HI, 32'h1111_1111);
        sample();

        #5;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
